ext_bus_arbiter: RTL and testbench

Shares the single 6-bit external memory/output bus of the tiny CPU between two requesters: port 0 (micro-sequencer instruction/immediate fetch) and port 1 (the `OUT` path). It sequences each read as address-drive, wait, then sample, and each write as data setup, one-cycle strobe, then release. Round-robin arbitration decides between simultaneous requests. The block sits between the CPU core and the `io_out[5:0]` / `io_out[7]` / `io_in[7:2]` pins.

---
 rtl/ext_bus_arbiter.sv | 114 +++++++++++
 tb/tb_ext_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arbiter.sv
// Two-port round-robin arbiter for the shared 6-bit external bus: sequences reads
// (address, wait, sample) and writes (setup, one-cycle strobe, release).
module ext_bus_arbiter #(
   parameter int AW          = 6,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_0,
   input  logic          req_1,
   input  logic          we_0,
   input  logic          we_1,
   input  logic [AW-1:0] payload_0,
   input  logic [AW-1:0] payload_1,
   output logic          gnt_0,
   output logic          gnt_1,
   output logic          ack_0,
   output logic          ack_1,
   output logic [AW-1:0] rdata_0,
   output logic [AW-1:0] rdata_1,
   output logic [AW-1:0] bus_out,
   output logic          bus_strobe,
   input  logic [AW-1:0] bus_in
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_SETUP, WR_STROBE} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t        state;
   logic [3:0]    cnt;
   logic          last;
   logic          owner;
   logic          turnaround;
   logic          winner;
   logic          win_we;
   logic [AW-1:0] win_payload;

   // On a tie the port that did not win last time gets the bus.
   always_comb begin
      winner      = (req_0 && req_1) ? ~last : req_1;
      win_we      = winner ? we_1 : we_0;
      win_payload = winner ? payload_1 : payload_0;
   end

   // The first IDLE edge after a completion never grants, so a requester has
   // the whole ack cycle to withdraw req before it would be sampled again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last       <= 1'b1;
         owner      <= 1'b0;
         turnaround <= 1'b0;
         gnt_0      <= 1'b0;
         gnt_1      <= 1'b0;
         ack_0      <= 1'b0;
         ack_1      <= 1'b0;
         rdata_0    <= '0;
         rdata_1    <= '0;
         bus_out    <= '0;
         bus_strobe <= 1'b0;
      end else begin
         gnt_0 <= 1'b0;
         gnt_1 <= 1'b0;
         ack_0 <= 1'b0;
         ack_1 <= 1'b0;
         case (state)
            IDLE: begin
               if (turnaround) begin
                  turnaround <= 1'b0;
               end else if (req_0 || req_1) begin
                  owner   <= winner;
                  last    <= winner;
                  gnt_0   <= ~winner;
                  gnt_1   <= winner;
                  bus_out <= win_payload;
                  if (win_we) begin
                     state <= WR_SETUP;
                  end else begin
                     state <= RD_WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (owner) rdata_1 <= bus_in;
                  else       rdata_0 <= bus_in;
                  ack_0      <= ~owner;
                  ack_1      <= owner;
                  turnaround <= 1'b1;
                  state      <= IDLE;
               end
            end
            WR_SETUP: begin
               bus_strobe <= 1'b1;
               state      <= WR_STROBE;
            end
            WR_STROBE: begin
               bus_strobe <= 1'b0;
               ack_0      <= ~owner;
               ack_1      <= owner;
               turnaround <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: one instance with WAIT_CYCLES=1, one with
// WAIT_CYCLES=0; memory model returns address+2 for every read.
module tb_ext_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_0, req_1, we_0, we_1;
   logic [5:0] payload_0, payload_1;
   logic       gnt_0, gnt_1, ack_0, ack_1, bus_strobe;
   logic [5:0] rdata_0, rdata_1, bus_out, bus_in;

   logic       z_req_0;
   logic [5:0] z_payload_0;
   logic       z_gnt_0, z_gnt_1, z_ack_0, z_ack_1, z_strobe;
   logic [5:0] z_rdata_0, z_rdata_1, z_bus_out, z_bus_in;

   int checkCount  = 0;
   int passCount   = 0;
   int cyc         = 0;
   int strobeCount = 0;

   always #5 clk = ~clk;

   assign bus_in   = bus_out + 6'd2;
   assign z_bus_in = z_bus_out + 6'd2;

   ext_bus_arbiter #(.AW(6), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
      .payload_0(payload_0), .payload_1(payload_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .ack_0(ack_0), .ack_1(ack_1),
      .rdata_0(rdata_0), .rdata_1(rdata_1),
      .bus_out(bus_out), .bus_strobe(bus_strobe), .bus_in(bus_in)
   );

   ext_bus_arbiter #(.AW(6), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_0(z_req_0), .req_1(1'b0), .we_0(1'b0), .we_1(1'b0),
      .payload_0(z_payload_0), .payload_1(6'd0),
      .gnt_0(z_gnt_0), .gnt_1(z_gnt_1), .ack_0(z_ack_0), .ack_1(z_ack_1),
      .rdata_0(z_rdata_0), .rdata_1(z_rdata_1),
      .bus_out(z_bus_out), .bus_strobe(z_strobe), .bus_in(z_bus_in)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [5:0] p0,
                                input logic r1, input logic w1, input logic [5:0] p1);
      req_0 = r0; we_0 = w0; payload_0 = p0;
      req_1 = r1; we_1 = w1; payload_1 = p1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus_strobe) strobeCount++;
   endtask

   int order [4];
   int when  [4];
   int nGnt;
   int overlap;
   int budget;
   int lastGnt;

   initial begin
      reset = 1'b1;
      z_req_0 = 1'b0; z_payload_0 = 6'd0;
      applyStimulus(1'b1, 1'b0, 6'd9, 1'b1, 1'b0, 6'd11);

      // Reset held two cycles with both ports requesting.
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst_gnt", 32'({gnt_0, gnt_1}), 32'd0);
         checkOutput("rst_ack", 32'({ack_0, ack_1}), 32'd0);
         checkOutput("rst_bus", 32'({bus_strobe, bus_out}), 32'd0);
         checkOutput("rst_rdata", 32'({rdata_0, rdata_1}), 32'd0);
      end
      reset = 1'b0;
      tick();
      checkOutput("first_gnt", 32'({gnt_0, gnt_1}), 32'b10);
      checkOutput("first_bus", 32'(bus_out), 32'd9);
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      tick();
      tick();
      checkOutput("first_ack", 32'(ack_0), 32'd1);
      checkOutput("first_rdata", 32'(rdata_0), 32'd11);
      tick();
      tick();

      // Single read, port 0, address 5.
      strobeCount = 0;
      applyStimulus(1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd0);
      tick();
      checkOutput("rd_gnt", 32'({gnt_0, gnt_1}), 32'b10);
      checkOutput("rd_bus_e0", 32'(bus_out), 32'd5);
      applyStimulus(1'b0, 1'b0, 6'd63, 1'b0, 1'b0, 6'd0);
      tick();
      checkOutput("rd_bus_e1", 32'(bus_out), 32'd5);
      checkOutput("rd_noack_e1", 32'({gnt_0, ack_0}), 32'd0);
      tick();
      checkOutput("rd_ack", 32'({ack_0, ack_1}), 32'b10);
      checkOutput("rd_rdata", 32'(rdata_0), 32'd7);
      tick();
      checkOutput("rd_ack_pulse", 32'(ack_0), 32'd0);
      checkOutput("rd_bus_hold", 32'(bus_out), 32'd5);
      tick();
      checkOutput("rd_nostrobe", 32'(strobeCount), 32'd0);

      // Single write, port 1, data 42.
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd42);
      tick();
      checkOutput("wr_gnt", 32'({gnt_0, gnt_1}), 32'b01);
      checkOutput("wr_bus_e0", 32'({bus_strobe, bus_out}), 32'd42);
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd1);
      tick();
      checkOutput("wr_strobe_e1", 32'({bus_strobe, bus_out}), 32'(7'd64 + 7'd42));
      checkOutput("wr_noack_e1", 32'(ack_1), 32'd0);
      tick();
      checkOutput("wr_strobe_e2", 32'({bus_strobe, bus_out}), 32'd42);
      checkOutput("wr_ack", 32'({ack_0, ack_1}), 32'b01);
      checkOutput("wr_rdata1", 32'(rdata_1), 32'd0);
      tick();
      tick();

      // Round robin: port 0 reads address 1, port 1 writes 2, both held.
      strobeCount = 0;
      nGnt = 0;
      overlap = 0;
      budget = 0;
      applyStimulus(1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 6'd2);
      while (nGnt < 4 && budget < 40) begin
         tick();
         budget++;
         if (gnt_0 && gnt_1) overlap++;
         if (gnt_0 || gnt_1) begin
            order[nGnt] = gnt_1 ? 1 : 0;
            when[nGnt]  = cyc;
            nGnt++;
         end
      end
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      checkOutput("rr_count", 32'(nGnt), 32'd4);
      for (int i = 0; i < 4; i++) checkOutput("rr_order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) checkOutput("rr_period", 32'(when[i] - when[i-1]), 32'd4);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("rr_overlap", 32'(overlap), 32'd0);
      checkOutput("rr_strobes", 32'(strobeCount), 32'd2);
      checkOutput("rr_rdata0", 32'(rdata_0), 32'd3);

      // Reset during WR_STROBE drops the write.
      applyStimulus(1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 6'd0);
      tick();
      checkOutput("mid_gnt", 32'(gnt_0), 32'd1);
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      tick();
      checkOutput("mid_strobe_hi", 32'(bus_strobe), 32'd1);
      reset = 1'b1;
      tick();
      checkOutput("mid_ack", 32'({ack_0, ack_1}), 32'd0);
      checkOutput("mid_bus", 32'({bus_strobe, bus_out}), 32'd0);
      checkOutput("mid_rdata0", 32'(rdata_0), 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("mid_noack", 32'({ack_0, ack_1}), 32'd0);
      applyStimulus(1'b1, 1'b0, 6'd3, 1'b0, 1'b0, 6'd0);
      tick();
      checkOutput("post_gnt", 32'(gnt_0), 32'd1);
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      tick();
      tick();
      checkOutput("post_ack", 32'(ack_0), 32'd1);
      checkOutput("post_rdata", 32'(rdata_0), 32'd5);

      // WAIT_CYCLES=0: back-to-back reads of 0..13 on port 0, req held.
      z_req_0 = 1'b1;
      lastGnt = 0;
      for (int a = 0; a < 14; a++) begin
         z_payload_0 = 6'(a);
         budget = 0;
         while (!z_gnt_0 && budget < 10) begin
            tick();
            budget++;
         end
         checkOutput("z_gnt", 32'(z_gnt_0), 32'd1);
         if (a > 0) checkOutput("z_period", 32'(cyc - lastGnt), 32'd3);
         lastGnt = cyc;
         z_payload_0 = 6'd63;
         tick();
         checkOutput("z_ack", 32'(z_ack_0), 32'd1);
         checkOutput("z_rdata", 32'(z_rdata_0), 32'(a + 2));
      end
      z_req_0 = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
